// File: rtl/bl_wl_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : bl_wl_config_loader
// Description : Streams a bitstream into NUM_BL-bit bit-line frames and strobes
//               the word lines one row at a time to program the fabric.
// Revision    : 1.0 - initial release
// ============================================================================
module bl_wl_config_loader #(
    parameter int NUM_BL   = 514,
    parameter int NUM_WL   = 407,
    parameter int DATA_W   = 32,
    parameter int WL_PULSE = 2
) (
    input  logic              clk,
    input  logic              global_resetn,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [NUM_BL-1:0] bl,
    output logic [NUM_WL-1:0] wl,
    output logic              busy,
    output logic              done
);

    localparam int W     = (NUM_BL + DATA_W - 1) / DATA_W;
    localparam int WC_W  = (W > 1)        ? $clog2(W)        : 1;
    localparam int ROW_W = (NUM_WL > 1)   ? $clog2(NUM_WL)   : 1;
    localparam int PC_W  = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;

    localparam logic [WC_W-1:0]  LAST_WORD  = WC_W'(W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(NUM_WL - 1);
    localparam logic [PC_W-1:0]  LAST_PULSE = PC_W'(WL_PULSE - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SETUP = 3'd2,
        S_PULSE = 3'd3,
        S_HOLD  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q,   row_d;
    logic [WC_W-1:0]    word_q,  word_d;
    logic [PC_W-1:0]    pcnt_q,  pcnt_d;
    logic [NUM_BL-1:0]  bl_q,    bl_d;
    logic [NUM_WL-1:0]  wl_q,    wl_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;

    logic [NUM_BL-1:0]  wr_en;
    logic [NUM_BL-1:0]  wr_data;
    logic [NUM_WL-1:0]  row_hot;

    // Each bit-line has a fixed home word and lane; bits past NUM_BL simply have no home.
    for (genvar b = 0; b < NUM_BL; b++) begin : g_bl_map
        assign wr_en[b]   = (word_q == WC_W'(b / DATA_W));
        assign wr_data[b] = in_data[b % DATA_W];
    end

    for (genvar r = 0; r < NUM_WL; r++) begin : g_wl_dec
        assign row_hot[r] = (row_q == ROW_W'(r));
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        word_d  = word_q;
        pcnt_d  = pcnt_q;
        bl_d    = bl_q;
        wl_d    = wl_q;

        case (state_q)
            S_IDLE: begin
                row_d  = '0;
                word_d = '0;
                bl_d   = '0;
                wl_d   = '0;
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (in_valid) begin
                    bl_d = (bl_q & ~wr_en) | (wr_data & wr_en);
                    if (word_q == LAST_WORD) begin
                        word_d  = '0;
                        state_d = S_SETUP;
                    end else begin
                        word_d = word_q + WC_W'(1);
                    end
                end
            end
            S_SETUP: begin
                wl_d    = row_hot;
                pcnt_d  = '0;
                state_d = S_PULSE;
            end
            S_PULSE: begin
                if (pcnt_q == LAST_PULSE) begin
                    wl_d    = '0;
                    state_d = S_HOLD;
                end else begin
                    pcnt_d = pcnt_q + PC_W'(1);
                end
            end
            S_HOLD: begin
                if (row_q == LAST_ROW) begin
                    bl_d    = '0;
                    state_d = S_DONE;
                end else begin
                    row_d   = row_q + ROW_W'(1);
                    word_d  = '0;
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                bl_d = '0;
                wl_d = '0;
                if (start) begin
                    row_d   = '0;
                    word_d  = '0;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status flags are registered from the next state so they line up with bl/wl.
        busy_d = (state_d == S_LOAD) || (state_d == S_SETUP) ||
                 (state_d == S_PULSE) || (state_d == S_HOLD);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge global_resetn) begin
        if (!global_resetn) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            word_q  <= '0;
            pcnt_q  <= '0;
            bl_q    <= '0;
            wl_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            word_q  <= word_d;
            pcnt_q  <= pcnt_d;
            bl_q    <= bl_d;
            wl_q    <= wl_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign in_ready = (state_q == S_LOAD);
    assign bl       = bl_q;
    assign wl       = wl_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bl_wl_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_bl_wl_config_loader
// Description : Self-checking bench: table vectors, random streams against a
//               timeline reference model, mid-pulse reset and start handling.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bl_wl_config_loader;

    localparam int NUM_BL   = 10;
    localparam int NUM_WL   = 3;
    localparam int DATA_W   = 4;
    localparam int WL_PULSE = 2;
    localparam int W        = (NUM_BL + DATA_W - 1) / DATA_W;
    localparam int WB       = NUM_WL * W * DATA_W;
    localparam int FB       = NUM_WL * NUM_BL;
    localparam int MAXN     = 400;

    typedef struct packed {
        logic [WB-1:0] words;   // word 0 in the least significant nibble
        logic [1:0]    vmode;   // 0 valid held, 1 toggling, 2 random
        logic          chk;     // compare captured frames against frames
        logic [FB-1:0] frames;  // row 0 frame in the least significant bits
        logic [7:0]    len;     // expected done edge, 0 = not tabulated
    } vec_t;

    logic              clk = 1'b0;
    logic              global_resetn = 1'b0;
    logic              start = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [NUM_BL-1:0] bl;
    logic [NUM_WL-1:0] wl;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    bl_wl_config_loader #(
        .NUM_BL   (NUM_BL),
        .NUM_WL   (NUM_WL),
        .DATA_W   (DATA_W),
        .WL_PULSE (WL_PULSE)
    ) u_dut (
        .clk           (clk),
        .global_resetn (global_resetn),
        .start         (start),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .bl            (bl),
        .wl            (wl),
        .busy          (busy),
        .done          (done)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Per-edge stimulus and expected outputs sampled just after edge n (edge 0 takes start).
    logic              drv_start [0:MAXN];
    logic              drv_valid [0:MAXN];
    logic [DATA_W-1:0] drv_data  [0:MAXN];
    logic [31:0]       e_bl      [0:MAXN];
    logic [NUM_WL-1:0] e_wl      [0:MAXN];
    logic              e_rdy     [0:MAXN];
    logic              e_busy    [0:MAXN];
    logic              e_done    [0:MAXN];
    int                n_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: each row needs W accepted words, then one setup cycle,
    // WL_PULSE cycles of word-line, one hold cycle; the pass ends after the last row.
    task automatic build_model(input logic [WB-1:0] words, input int vmode);
        int n;
        int idx;
        logic [31:0] cur;
        logic [31:0] msk;
        logic [31:0] wmsk;
        logic [31:0] wv;
        msk  = (32'd1 << NUM_BL) - 32'd1;
        wmsk = (32'd1 << DATA_W) - 32'd1;
        for (int i = 0; i <= MAXN; i++) begin
            drv_start[i] = (i == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
            case (vmode)
                0:       drv_valid[i] = 1'b1;
                1:       drv_valid[i] = (i % 2 == 1);
                default: drv_valid[i] = (i > MAXN / 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
            endcase
            drv_data[i] = DATA_W'($urandom);
            e_bl[i]     = '0;
            e_wl[i]     = '0;
            e_rdy[i]    = 1'b0;
            e_busy[i]   = 1'b1;
            e_done[i]   = 1'b0;
        end
        n        = 0;
        idx      = 0;
        cur      = '0;
        e_rdy[0] = 1'b1;
        for (int r = 0; r < NUM_WL; r++) begin
            for (int k = 0; k < W; k++) begin
                do begin
                    n++;
                    e_rdy[n] = 1'b1;
                    if (drv_valid[n]) begin
                        wv  = 32'(words[idx*DATA_W +: DATA_W]);
                        cur = ((cur & ~(wmsk << (k * DATA_W))) | (wv << (k * DATA_W))) & msk;
                        drv_data[n] = words[idx*DATA_W +: DATA_W];
                    end
                    e_bl[n] = cur;
                end while (!drv_valid[n]);
                idx++;
                if (k == W - 1) e_rdy[n] = 1'b0;
            end
            for (int p = 0; p < WL_PULSE; p++) begin
                n++;
                e_wl[n] = NUM_WL'(1) << r;
                e_bl[n] = cur;
            end
            n++;
            e_bl[n] = cur;
            n++;
            if (r == NUM_WL - 1) begin
                e_busy[n] = 1'b0;
                e_done[n] = 1'b1;
            end else begin
                e_rdy[n] = 1'b1;
                e_bl[n]  = cur;
            end
        end
        n_done = n;
        for (int i = n + 1; i <= n + 3; i++) begin
            drv_start[i] = 1'b0;
            e_busy[i]    = 1'b0;
            e_done[i]    = 1'b1;
        end
    endtask

    // Applies one pass; if abort_row >= 0, drops reset as soon as that row's word line is seen.
    task automatic run_pass(input vec_t tv, input int abort_row);
        int          dut_done_n;
        int          plen [NUM_WL];
        logic [31:0] cap  [NUM_WL];
        logic        aborted;
        dut_done_n = -1;
        aborted    = 1'b0;
        for (int r = 0; r < NUM_WL; r++) begin
            plen[r] = 0;
            cap[r]  = '0;
        end
        build_model(tv.words, int'(tv.vmode));
        for (int n = 0; n <= n_done + 3; n++) begin
            start    = drv_start[n];
            in_valid = drv_valid[n];
            in_data  = drv_data[n];
            @(posedge clk);
            #1;
            check("wl", 32'(wl), 32'(e_wl[n]));
            check("bl", 32'(bl), e_bl[n]);
            check("in_ready", 32'(in_ready), 32'(e_rdy[n]));
            check("busy", 32'(busy), 32'(e_busy[n]));
            check("done", 32'(done), 32'(e_done[n]));
            for (int r = 0; r < NUM_WL; r++) begin
                if (wl[r]) begin
                    plen[r]++;
                    if (plen[r] == 1) cap[r] = 32'(bl);
                end
            end
            if (done && dut_done_n < 0) dut_done_n = n;
            if (abort_row >= 0 && wl[abort_row]) begin
                #2;
                global_resetn = 1'b0;
                #1;
                check("rst_wl", 32'(wl), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_bl", 32'(bl), 32'd0);
                check("rst_in_ready", 32'(in_ready), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                aborted = 1'b1;
                break;
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        if (abort_row >= 0) begin
            check("abort_reached", 32'(aborted), 32'd1);
        end else begin
            check("done_edge", 32'(dut_done_n), 32'(n_done));
            if (tv.len != 0) check("done_edge_tab", 32'(dut_done_n), 32'(tv.len));
            for (int r = 0; r < NUM_WL; r++) begin
                check("pulse_len", 32'(plen[r]), 32'(WL_PULSE));
                if (tv.chk) check("frame", cap[r], 32'(tv.frames[r*NUM_BL +: NUM_BL]));
            end
        end
    endtask

    initial begin
        vec_t        tab [5];
        vec_t        rv;
        logic [63:0] rnd;

        tab[0] = '{words: {4'h2, 4'h0, 4'h0, 4'h3, 4'h2, 4'h1, 4'hF, 4'h5, 4'hA}, vmode: 2'd0,
                   chk: 1'b1, frames: {10'h200, 10'h321, 10'h35A}, len: 8'd21};
        tab[1] = '{words: {4'h2, 4'h0, 4'h0, 4'h3, 4'h2, 4'h1, 4'hF, 4'h5, 4'hA}, vmode: 2'd1,
                   chk: 1'b1, frames: {10'h200, 10'h321, 10'h35A}, len: 8'd0};
        tab[2] = '{words: {4'h2, 4'h0, 4'h0, 4'h3, 4'h2, 4'h1, 4'h3, 4'h5, 4'hA}, vmode: 2'd0,
                   chk: 1'b1, frames: {10'h200, 10'h321, 10'h35A}, len: 8'd21};
        tab[3] = '{words: {9{4'hF}}, vmode: 2'd0,
                   chk: 1'b1, frames: {10'h3FF, 10'h3FF, 10'h3FF}, len: 8'd21};
        tab[4] = '{words: {4'hC, 4'hE, 4'h7, 4'h1, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0}, vmode: 2'd1,
                   chk: 1'b1, frames: {10'h0E7, 10'h148, 10'h000}, len: 8'd0};

        // Reset state, then idle with junk on the stream
        repeat (3) @(posedge clk);
        #1;
        check("rst_bl", 32'(bl), 32'd0);
        check("rst_wl", 32'(wl), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        global_resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom);
            in_data  = DATA_W'($urandom);
            @(posedge clk);
            #1;
            check("idle_bl", 32'(bl), 32'd0);
            check("idle_wl", 32'(wl), 32'd0);
            check("idle_in_ready", 32'(in_ready), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
        end
        in_valid = 1'b0;

        for (int t = 0; t < 5; t++) run_pass(tab[t], -1);

        // Reset while row 1 is being strobed, then a clean pass from row 0
        run_pass(tab[0], 1);
        repeat (2) @(posedge clk);
        #1;
        global_resetn = 1'b1;
        run_pass(tab[0], -1);

        for (int i = 0; i < 20; i++) begin
            rnd       = {$urandom, $urandom};
            rv.words  = rnd[WB-1:0];
            rv.vmode  = 2'd2;
            rv.chk    = 1'b0;
            rv.frames = '0;
            rv.len    = 8'd0;
            run_pass(rv, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
